// File: rtl/fifo_write_arbiter.sv
// Round-robin write-port arbiter for a single-port FIFO. Bursts are bounded
// to MAX_BURST beats per grant, and handover between owners costs no idle cycle.
module fifo_write_arbiter #(
  parameter int N_REQ     = 4,
  parameter int DW        = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                arb_en,
  input  logic [N_REQ-1:0]    req_valid,
  input  logic [N_REQ*DW-1:0] req_data,
  output logic [N_REQ-1:0]    req_ready,
  input  logic                fifo_full,
  output logic                fifo_w_en,
  output logic [DW-1:0]       fifo_data,
  output logic [N_REQ-1:0]    grant,
  output logic [3:0]          beat_cnt,
  output logic                busy
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic {IDLE, OWN} state_t;

  state_t           state, state_nxt;
  logic [N_REQ-1:0] grant_nxt;
  logic [PW-1:0]    rr_ptr, rr_ptr_nxt;
  logic [3:0]       beat_nxt;
  logic             owner_vld;
  logic             xfer;
  logic             last_beat;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (int'(p) >= N_REQ - 1) return '0;
    return p + 1'b1;
  endfunction

  // One-hot of the first valid requester at or after start, wrapping around.
  function automatic logic [N_REQ-1:0] rr_select(input logic [N_REQ-1:0] v,
                                                 input logic [PW-1:0]    start);
    logic [N_REQ-1:0] oh;
    int               idx;
    oh = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = int'(start) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (v[idx]) begin
        oh      = '0;
        oh[idx] = 1'b1;
      end
    end
    return oh;
  endfunction

  function automatic logic [PW-1:0] oh_index(input logic [N_REQ-1:0] oh);
    logic [PW-1:0] ix;
    ix = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (oh[i]) ix = PW'(i);
    end
    return ix;
  endfunction

  assign owner_vld = |(grant & req_valid);
  assign xfer      = owner_vld & ~fifo_full;
  assign last_beat = xfer && (beat_cnt + 4'd1 == 4'(MAX_BURST));

  assign req_ready = grant & {N_REQ{~fifo_full}};
  assign fifo_w_en = xfer;
  assign busy      = (state == OWN);

  always_comb begin
    fifo_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) fifo_data = fifo_data | req_data[i*DW +: DW];
    end
  end

  always_comb begin
    state_nxt  = state;
    grant_nxt  = grant;
    rr_ptr_nxt = rr_ptr;
    beat_nxt   = beat_cnt;
    case (state)
      IDLE: begin
        if (arb_en && |req_valid) begin
          state_nxt = OWN;
          grant_nxt = rr_select(req_valid, rr_ptr);
          beat_nxt  = '0;
        end
      end
      OWN: begin
        if (xfer) beat_nxt = beat_cnt + 4'd1;
        // Release on a full burst or on the owner dropping valid (even while full).
        if (!owner_vld || last_beat) begin
          rr_ptr_nxt = ptr_inc(oh_index(grant));
          beat_nxt   = '0;
          if (arb_en && |req_valid) begin
            grant_nxt = rr_select(req_valid, rr_ptr_nxt);
          end else begin
            state_nxt = IDLE;
            grant_nxt = '0;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      grant    <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      grant    <= grant_nxt;
      rr_ptr   <= rr_ptr_nxt;
      beat_cnt <= beat_nxt;
    end
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Scoreboard bench for fifo_write_arbiter: expected FIFO writes are queued as
// stimulus is set up and popped as the DUT writes.
module tb_fifo_write_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        arb_en;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        fifo_full;
  logic        fifo_w_en;
  logic [7:0]  fifo_data;
  logic [3:0]  grant;
  logic [3:0]  beat_cnt;
  logic        busy;

  typedef struct {
    logic [7:0] data;
    logic [3:0] grant;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] base[4];
  logic [7:0] cnt[4];
  logic [3:0] hs;
  int         n_checks = 0;
  int         n_fail   = 0;

  fifo_write_arbiter #(.N_REQ(4), .DW(8), .MAX_BURST(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .arb_en    (arb_en),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .fifo_full (fifo_full),
    .fifo_w_en (fifo_w_en),
    .fifo_data (fifo_data),
    .grant     (grant),
    .beat_cnt  (beat_cnt),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < 4; i++) req_data[i*8 +: 8] = base[i] + cnt[i];
  endtask

  task automatic push(input logic [7:0] d, input logic [3:0] g);
    exp_t e;
    e.data  = d;
    e.grant = g;
    exp_q.push_back(e);
  endtask

  // Called at a negedge; returns at the following negedge with outputs settled.
  task automatic cycle();
    exp_t e;
    #1;
    hs = req_valid & req_ready;
    if (fifo_w_en) begin
      if (exp_q.size() == 0) begin
        check_eq("wr_unexpected", {24'h0, fifo_data}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check_eq("wr_data", {24'h0, fifo_data}, {24'h0, e.data});
        check_eq("wr_grant", {28'h0, grant}, {28'h0, e.grant});
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) if (hs[i]) cnt[i] = cnt[i] + 8'd1;
    drive();
    @(negedge clk);
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    req_valid = '0;
    fifo_full = 1'b0;
    arb_en    = 1'b1;
    for (int i = 0; i < 4; i++) cnt[i] = '0;
    drive();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b0;
    arb_en    = 1'b1;
    req_valid = '0;
    fifo_full = 1'b0;
    for (int i = 0; i < 4; i++) begin
      base[i] = '0;
      cnt[i]  = '0;
    end
    drive();
    #3;
    check_eq("rst_grant", {28'h0, grant}, 32'h0);
    check_eq("rst_busy", {31'h0, busy}, 32'h0);
    check_eq("rst_wen", {31'h0, fifo_w_en}, 32'h0);
    check_eq("rst_beat", {28'h0, beat_cnt}, 32'h0);
    check_eq("rst_ready", {28'h0, req_ready}, 32'h0);
    check_eq("rst_data", {24'h0, fifo_data}, 32'h0);
    @(negedge clk);

    // Single requester: bursts of 4 with zero-bubble re-grant to itself
    do_reset();
    base[0] = 8'h11;
    req_valid = 4'b0001;
    drive();
    cycle();
    check_eq("t1_grant", {28'h0, grant}, 32'h1);
    check_eq("t1_busy", {31'h0, busy}, 32'h1);
    check_eq("t1_beat0", {28'h0, beat_cnt}, 32'h0);
    for (int k = 0; k < 6; k++) push(8'h11 + 8'(k), 4'b0001);
    for (int k = 0; k < 4; k++) begin
      cycle();
      check_eq("t1_beat", {28'h0, beat_cnt}, 32'((k + 1) % 4));
      check_eq("t1_hold", {28'h0, grant}, 32'h1);
    end
    cycle();
    cycle();
    req_valid = 4'b0000;
    cycle();
    check_eq("t1_idle", {28'h0, grant}, 32'h0);
    check_eq("t1_qempty", 32'(exp_q.size()), 32'h0);

    // All valid: round-robin 0,1,2,3,0 with 4 beats each
    do_reset();
    for (int i = 0; i < 4; i++) base[i] = 8'h20 + 8'(16 * i);
    req_valid = 4'b1111;
    drive();
    cycle();
    for (int b = 0; b < 5; b++)
      for (int k = 0; k < 4; k++) push(base[b % 4] + 8'(4 * (b / 4)) + 8'(k), 4'(1 << (b % 4)));
    for (int b = 0; b < 5; b++) begin
      for (int k = 0; k < 4; k++) begin
        check_eq("t2_grant", {28'h0, grant}, 32'(1 << (b % 4)));
        check_eq("t2_busy", {31'h0, busy}, 32'h1);
        cycle();
      end
    end
    check_eq("t2_next", {28'h0, grant}, 32'h2);
    req_valid = 4'b0000;
    cycle();
    check_eq("t2_idle", {31'h0, busy}, 32'h0);
    check_eq("t2_qempty", 32'(exp_q.size()), 32'h0);

    // Full stall in the middle of requester 2's burst
    do_reset();
    base[2] = 8'h60;
    req_valid = 4'b0100;
    drive();
    cycle();
    check_eq("t3_grant", {28'h0, grant}, 32'h4);
    for (int k = 0; k < 4; k++) push(8'h60 + 8'(k), 4'b0100);
    cycle();
    cycle();
    check_eq("t3_beat2", {28'h0, beat_cnt}, 32'h2);
    fifo_full = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      check_eq("t3_ready", {28'h0, req_ready}, 32'h0);
      check_eq("t3_wen", {31'h0, fifo_w_en}, 32'h0);
      check_eq("t3_beat", {28'h0, beat_cnt}, 32'h2);
      check_eq("t3_grant_hold", {28'h0, grant}, 32'h4);
      cycle();
    end
    fifo_full = 1'b0;
    cycle();
    check_eq("t3_beat3", {28'h0, beat_cnt}, 32'h3);
    push(8'h64, 4'b0100);
    cycle();
    check_eq("t3_release", {28'h0, beat_cnt}, 32'h0);
    check_eq("t3_regrant", {28'h0, grant}, 32'h4);
    cycle();
    req_valid = 4'b0000;
    cycle();
    check_eq("t3_qempty", 32'(exp_q.size()), 32'h0);

    // Requester 1 drops valid after one beat; requester 3 takes over
    do_reset();
    base[1] = 8'h70;
    base[3] = 8'h90;
    req_valid = 4'b1010;
    drive();
    cycle();
    check_eq("t4_grant", {28'h0, grant}, 32'h2);
    push(8'h70, 4'b0010);
    cycle();
    check_eq("t4_beat1", {28'h0, beat_cnt}, 32'h1);
    req_valid = 4'b1000;
    cycle();
    check_eq("t4_handover", {28'h0, grant}, 32'h8);
    check_eq("t4_beat0", {28'h0, beat_cnt}, 32'h0);
    push(8'h90, 4'b1000);
    push(8'h91, 4'b1000);
    cycle();
    cycle();
    req_valid = 4'b0000;
    cycle();
    check_eq("t4_qempty", 32'(exp_q.size()), 32'h0);

    // arb_en dropped mid-burst: burst completes, then no new grant until re-enabled
    do_reset();
    for (int i = 0; i < 4; i++) base[i] = 8'hB0 + 8'(16 * i);
    req_valid = 4'b1111;
    drive();
    cycle();
    for (int k = 0; k < 4; k++) push(8'hB0 + 8'(k), 4'b0001);
    cycle();
    arb_en = 1'b0;
    cycle();
    cycle();
    cycle();
    check_eq("t5_grant0", {28'h0, grant}, 32'h0);
    check_eq("t5_busy0", {31'h0, busy}, 32'h0);
    cycle();
    check_eq("t5_stay_idle", {28'h0, grant}, 32'h0);
    arb_en = 1'b1;
    cycle();
    check_eq("t5_regrant", {28'h0, grant}, 32'h2);
    req_valid = 4'b0000;
    cycle();
    check_eq("t5_qempty", 32'(exp_q.size()), 32'h0);

    // Asynchronous reset between edges in the middle of a burst
    do_reset();
    base[0] = 8'hA0;
    req_valid = 4'b0001;
    drive();
    cycle();
    push(8'hA0, 4'b0001);
    push(8'hA1, 4'b0001);
    cycle();
    cycle();
    #2 rst_n = 1'b0;
    #1;
    check_eq("t6_grant", {28'h0, grant}, 32'h0);
    check_eq("t6_ready", {28'h0, req_ready}, 32'h0);
    check_eq("t6_wen", {31'h0, fifo_w_en}, 32'h0);
    check_eq("t6_busy", {31'h0, busy}, 32'h0);
    check_eq("t6_beat", {28'h0, beat_cnt}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    req_valid = 4'b1111;
    drive();
    cycle();
    check_eq("t6_first", {28'h0, grant}, 32'h1);
    req_valid = 4'b0000;
    cycle();
    check_eq("t6_qempty", 32'(exp_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
